sgpr: RTL and testbench

SGPR -- requirements
Module: sgpr

---
 rtl/sgpr_pkg.sv | 9 +
 rtl/sgpr_wdec.sv | 20 ++
 rtl/sgpr.sv | 55 +++++
 tb/tb_sgpr.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/sgpr_pkg.sv
// Shared constants and typedefs for the scalar register file.
package sgpr_pkg;
    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 5;
    localparam int NUM_REGS   = 2 ** ADDR_WIDTH;

    typedef logic [ADDR_WIDTH-1:0] reg_idx_t;
    typedef logic [DATA_WIDTH-1:0] reg_word_t;
endpackage

// File: rtl/sgpr_wdec.sv
// Write-address decoder: one-hot per-register write enable, bit 0 never set.
module sgpr_wdec
    import sgpr_pkg::*;
#(
    parameter int ADDR_WIDTH = sgpr_pkg::ADDR_WIDTH,
    parameter int NUM_REGS   = 2 ** ADDR_WIDTH
) (
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic                  we,
    output logic [NUM_REGS-1:0]   wen
);

    // Register 0 is hardwired to zero, so it never gets an enable.
    assign wen[0] = 1'b0;

    for (genvar i = 1; i < NUM_REGS; i++) begin : g_dec
        assign wen[i] = we && (waddr == ADDR_WIDTH'(i));
    end

endmodule

// File: rtl/sgpr.sv
// Scalar register file: one write port, two combinational read ports, r0 reads zero.
module sgpr
    import sgpr_pkg::*;
#(
    parameter int DATA_WIDTH = sgpr_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = sgpr_pkg::ADDR_WIDTH,
    parameter int NUM_REGS   = 2 ** ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  test_en_i,
    input  logic [ADDR_WIDTH-1:0] raddr_a_i,
    output logic [DATA_WIDTH-1:0] rdata_a_o,
    input  logic [ADDR_WIDTH-1:0] raddr_b_i,
    output logic [DATA_WIDTH-1:0] rdata_b_o,
    input  logic [ADDR_WIDTH-1:0] waddr_a_i,
    input  logic [DATA_WIDTH-1:0] wdata_a_i,
    input  logic                  we_a_i
);

    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs;
    logic [NUM_REGS-1:0]                 wen;
    logic                                unused_test_en;

    // Reserved for clock-gating test bypass; deliberately has no functional effect.
    assign unused_test_en = test_en_i;

    sgpr_wdec #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .NUM_REGS  (NUM_REGS)
    ) u_wdec (
        .waddr(waddr_a_i),
        .we   (we_a_i),
        .wen  (wen)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            regs <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wen[i]) regs[i] <= wdata_a_i;
            end
        end
    end

    // Index 0 is forced to zero at the mux so it reads 0 even before the first reset.
    always_comb begin
        rdata_a_o = '0;
        rdata_b_o = '0;
        if (raddr_a_i != '0) rdata_a_o = regs[raddr_a_i];
        if (raddr_b_i != '0) rdata_b_o = regs[raddr_b_i];
    end

endmodule

// File: tb/tb_sgpr.sv
// Randomized + directed scoreboard bench for sgpr against an array reference model.
module tb_sgpr;
    import sgpr_pkg::*;

    logic      clk = 1'b0;
    logic      rst_n = 1'b0;
    logic      test_en_i = 1'b0;
    reg_idx_t  raddr_a_i = '0;
    reg_idx_t  raddr_b_i = '0;
    reg_idx_t  waddr_a_i = '0;
    reg_word_t wdata_a_i = '0;
    logic      we_a_i = 1'b0;
    reg_word_t rdata_a_o;
    reg_word_t rdata_b_o;

    typedef struct {
        reg_idx_t  ra;
        reg_idx_t  rb;
        reg_word_t exp_a;
        reg_word_t exp_b;
    } exp_t;

    exp_t      sb[$];
    reg_word_t mdl[NUM_REGS];
    int        n_vec = 0;
    int        n_err = 0;

    always #5 clk = ~clk;

    sgpr dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .test_en_i(test_en_i),
        .raddr_a_i(raddr_a_i),
        .rdata_a_o(rdata_a_o),
        .raddr_b_i(raddr_b_i),
        .rdata_b_o(rdata_b_o),
        .waddr_a_i(waddr_a_i),
        .wdata_a_i(wdata_a_i),
        .we_a_i   (we_a_i)
    );

    function automatic reg_word_t model_read(reg_idx_t idx);
        return (idx == 0) ? '0 : mdl[idx];
    endfunction

    // One cycle: commit what the previous edge did to the model, then drive new inputs
    // and queue the read values they must produce before the next edge.
    task automatic apply(input logic rst, input logic we, input reg_idx_t wa,
                         input reg_word_t wd, input reg_idx_t ra, input reg_idx_t rb,
                         input logic te);
        exp_t e;
        @(posedge clk);
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) mdl[i] = '0;
        end else if (we_a_i && waddr_a_i != 0) begin
            mdl[waddr_a_i] = wdata_a_i;
        end
        #1;
        rst_n = rst; we_a_i = we; waddr_a_i = wa; wdata_a_i = wd;
        raddr_a_i = ra; raddr_b_i = rb; test_en_i = te;
        e.ra = ra; e.rb = rb;
        e.exp_a = model_read(ra);
        e.exp_b = model_read(rb);
        sb.push_back(e);
    endtask

    // Monitor: read data is checked mid-cycle, away from the active edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                n_vec++;
                if (rdata_a_o !== e.exp_a) begin
                    n_err++;
                    $display("FAIL rdata_a idx=%0d got=%h exp=%h t=%0t", e.ra, rdata_a_o, e.exp_a, $time);
                end
                n_vec++;
                if (rdata_b_o !== e.exp_b) begin
                    n_err++;
                    $display("FAIL rdata_b idx=%0d got=%h exp=%h t=%0t", e.rb, rdata_b_o, e.exp_b, $time);
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < NUM_REGS; i++) mdl[i] = '0;
        // Reset state: every index reads 0
        apply(0, 0, 0, 0, 1, 2, 0);
        apply(0, 1, 4, 32'h1111, 31, 0, 0);
        // Write 100 to r10, then hold with we=0 and changed data
        apply(1, 1, 10, 100, 10, 10, 0);
        apply(1, 0, 10, 55, 10, 10, 0);
        apply(1, 0, 10, 55, 10, 10, 0);
        // Writes to r0 are discarded
        apply(1, 1, 0, 32'hDEADBEEF, 0, 0, 0);
        apply(1, 0, 0, 0, 0, 0, 0);
        // Top index on both ports
        apply(1, 1, 31, 32'h12345678, 31, 31, 0);
        apply(1, 0, 0, 0, 31, 31, 0);
        // No write-to-read bypass: old value before the edge, new after
        apply(1, 1, 5, 7, 0, 0, 0);
        apply(1, 1, 5, 9, 5, 5, 0);
        apply(1, 0, 5, 0, 5, 5, 0);
        // Fill 1..31, then reset wins over a simultaneous write
        for (int i = 1; i < NUM_REGS; i++)
            apply(1, 1, reg_idx_t'(i), reg_word_t'(i), reg_idx_t'(i - 1), reg_idx_t'(i), 0);
        apply(0, 1, 3, 77, 3, 17, 0);
        for (int i = 0; i < NUM_REGS; i += 2)
            apply(1, 0, 0, 0, reg_idx_t'(i), reg_idx_t'(i + 1), 0);
        // test_en toggling has no effect on a write
        apply(1, 1, 8, 42, 0, 8, 1);
        apply(1, 0, 8, 0, 8, 8, 0);
        apply(1, 0, 8, 0, 7, 8, 1);
        // Randomized traffic with occasional resets and address collisions
        for (int n = 0; n < 600; n++) begin
            logic     rst, we, te;
            reg_idx_t wa, ra, rb;
            rst = ($urandom_range(0, 39) != 0);
            we  = $urandom_range(0, 1) == 1;
            te  = $urandom_range(0, 1) == 1;
            wa  = reg_idx_t'($urandom_range(0, NUM_REGS - 1));
            ra  = ($urandom_range(0, 3) == 0) ? waddr_a_i : reg_idx_t'($urandom_range(0, NUM_REGS - 1));
            rb  = ($urandom_range(0, 3) == 0) ? ra : reg_idx_t'($urandom_range(0, NUM_REGS - 1));
            apply(rst, we, wa, reg_word_t'($urandom), ra, rb, te);
        end
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain left=%0d exp=0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
